// File: rtl/pe_pkg.sv
// Shared definitions for the output-stationary systolic PE: data-type and precision
// encodings, the result-chain record and a width-generic saturating adder.
package pe_pkg;

  localparam logic PE_DATA_TYPE_A = 1'b0;
  localparam logic PE_DATA_TYPE_C = 1'b1;
  localparam logic PRECISION_INT8 = 1'b0;
  localparam logic PRECISION_INT4 = 1'b1;

  // Widest accumulator supported; ACC_W must be strictly smaller.
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [SAT_MAX_W-1:0] data;
  } res_chain_t;

  typedef struct packed {
    logic                 sat;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the sum to the signed range of w bits.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input int                          w);
    logic signed [SAT_MAX_W:0] full;
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sat_res_t                  r;
    one    = '0;
    one[0] = 1'b1;
    hi     = (one << (w - 1)) - one;
    lo     = -(one << (w - 1));
    full   = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    r.sat  = 1'b0;
    r.sum  = full[SAT_MAX_W-1:0];
    if (full > hi) begin
      r.sat = 1'b1;
      r.sum = hi[SAT_MAX_W-1:0];
    end else if (full < lo) begin
      r.sat = 1'b1;
      r.sum = lo[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_dot_lane.sv
// Combinational LANES-wide signed dot product; int4 mode treats every byte as two
// signed nibbles (low nibble first) and sums all 2*LANES nibble products.
module pe_dot_lane
  import pe_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  parameter int OUT_W  = 32
) (
  input  logic        [LANES*ELEM_W-1:0] a_i,
  input  logic        [LANES*ELEM_W-1:0] b_i,
  input  logic                           prec_i,
  output logic signed [OUT_W-1:0]        dot_o
);

  localparam int HW = ELEM_W / 2;
  localparam int PW = 2 * ELEM_W;

  logic signed [PW-1:0]     p8;
  logic signed [ELEM_W-1:0] p4_lo;
  logic signed [ELEM_W-1:0] p4_hi;
  logic signed [OUT_W-1:0]  sum8;
  logic signed [OUT_W-1:0]  sum4;

  always_comb begin
    sum8  = '0;
    sum4  = '0;
    p8    = '0;
    p4_lo = '0;
    p4_hi = '0;
    for (int i = 0; i < LANES; i++) begin
      p8    = PW'($signed(a_i[i*ELEM_W +: ELEM_W])) * PW'($signed(b_i[i*ELEM_W +: ELEM_W]));
      p4_lo = ELEM_W'($signed(a_i[i*ELEM_W +: HW])) * ELEM_W'($signed(b_i[i*ELEM_W +: HW]));
      p4_hi = ELEM_W'($signed(a_i[i*ELEM_W+HW +: HW])) * ELEM_W'($signed(b_i[i*ELEM_W+HW +: HW]));
      sum8  = sum8 + OUT_W'(p8);
      sum4  = sum4 + OUT_W'(p4_lo) + OUT_W'(p4_hi);
    end
    dot_o = (prec_i == PRECISION_INT4) ? sum4 : sum8;
  end

endmodule

// File: rtl/pe_os_lane.sv
// Output-stationary systolic PE with C preload and a token-driven result drain chain.
// Optional macro PE_OS_SAT_EN: saturating accumulation (first saturation sets err_o).
module pe_os_lane
  import pe_pkg::*;
#(
  parameter int X        = 0,
  parameter int Y        = 0,
  parameter int SARRAY_W = 4,
  parameter int LANES    = 4,
  parameter int ELEM_W   = 8,
  parameter int ACC_W    = 32,
  parameter int CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      top_data_valid_i,
  input  logic [CNT_W-1:0]          top_data_cnt_i,
  input  logic [LANES*ELEM_W-1:0]   top_data_i,
  input  logic                      top_storec_valid_i,
  input  logic                      top_res_valid_i,
  input  logic [ACC_W-1:0]          top_res_i,
  input  logic                      left_data_valid_i,
  input  logic [CNT_W-1:0]          left_data_cnt_i,
  input  logic                      left_data_type_i,
  input  logic                      left_precision_i,
  input  logic [LANES*ELEM_W-1:0]   left_data_i,
  output logic                      bot_data_valid_o,
  output logic [CNT_W-1:0]          bot_data_cnt_o,
  output logic [LANES*ELEM_W-1:0]   bot_data_o,
  output logic                      bot_storec_valid_o,
  output logic                      bot_res_valid_o,
  output logic [ACC_W-1:0]          bot_res_o,
  output logic                      right_data_valid_o,
  output logic [CNT_W-1:0]          right_data_cnt_o,
  output logic                      right_data_type_o,
  output logic                      right_precision_o,
  output logic [LANES*ELEM_W-1:0]   right_data_o,
  output logic                      err_o
);

  localparam int                DW     = LANES * ELEM_W;
  localparam logic [CNT_W-1:0]  MY_CNT = CNT_W'(SARRAY_W - 1 - X);
  // Row position is implied by where the token arrives; the PE itself never needs it.
  localparam int                unused_row_idx = Y;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    err_q, err_d;
  logic [1:0]              tok_q, tok_d;
  logic                    bot_v_q, bot_v_d;
  logic [CNT_W-1:0]        bot_cnt_q, bot_cnt_d;
  logic [DW-1:0]           bot_data_q, bot_data_d;
  logic                    right_v_q, right_v_d;
  logic [CNT_W-1:0]        right_cnt_q, right_cnt_d;
  logic                    right_type_q, right_type_d;
  logic                    right_prec_q, right_prec_d;
  logic [DW-1:0]           right_data_q, right_data_d;
  logic                    res_v_q;
  logic [ACC_W-1:0]        res_q;

  logic signed [ACC_W-1:0] dot;
  logic signed [ACC_W-1:0] mac_sum;
  logic signed [ACC_W-1:0] acc_upd;
  logic                    a_valid, is_c, c_hit, mac_fire, fwd_right;
  logic                    lone, collision, sat_evt;
  res_chain_t              res_d;

  pe_dot_lane #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W),
    .OUT_W  (ACC_W)
  ) u_dot (
    .a_i    (left_data_i),
    .b_i    (top_data_i),
    .prec_i (left_precision_i),
    .dot_o  (dot)
  );

`ifdef PE_OS_SAT_EN
  sat_res_t sat_r;
  logic [SAT_MAX_W-ACC_W-1:0] unused_sat_hi;
  assign sat_r         = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(dot), ACC_W);
  assign mac_sum       = sat_r.sum[ACC_W-1:0];
  assign sat_evt       = mac_fire && sat_r.sat;
  assign unused_sat_hi = sat_r.sum[SAT_MAX_W-1:ACC_W];
`else
  assign mac_sum = acc_q + dot;
  assign sat_evt = 1'b0;
`endif

  logic [SAT_MAX_W-ACC_W-1:0] unused_res_hi;
  assign unused_res_hi = res_d.data[SAT_MAX_W-1:ACC_W];

  always_comb begin
    a_valid   = left_data_valid_i && (left_data_type_i == PE_DATA_TYPE_A);
    is_c      = left_data_valid_i && (left_data_type_i == PE_DATA_TYPE_C);
    c_hit     = is_c && (left_data_cnt_i == MY_CNT);
    mac_fire  = top_data_valid_i && a_valid;
    lone      = (top_data_valid_i && !a_valid) || (a_valid && !top_data_valid_i);
    fwd_right = mac_fire || (is_c && !c_hit);

    // The drain snapshot includes a MAC landing in the same cycle.
    acc_upd = mac_fire ? mac_sum : acc_q;
    if (c_hit) begin
      acc_d = $signed(left_data_i[ACC_W-1:0]);
    end else if (top_storec_valid_i) begin
      acc_d = '0;
    end else begin
      acc_d = acc_upd;
    end

    res_d     = '0;
    collision = 1'b0;
    if (top_storec_valid_i) begin
      res_d.valid = 1'b1;
      res_d.data  = SAT_MAX_W'(acc_upd);
      collision   = top_res_valid_i;
    end else begin
      res_d.valid = top_res_valid_i;
      res_d.data  = SAT_MAX_W'(top_res_i);
    end

    tok_d = {tok_q[0], top_storec_valid_i};
    err_d = err_q | lone | collision | sat_evt;

    bot_v_d      = mac_fire;
    bot_cnt_d    = mac_fire ? top_data_cnt_i : bot_cnt_q;
    bot_data_d   = mac_fire ? top_data_i : bot_data_q;
    right_v_d    = fwd_right;
    right_cnt_d  = fwd_right ? left_data_cnt_i : right_cnt_q;
    right_type_d = fwd_right ? left_data_type_i : right_type_q;
    right_prec_d = fwd_right ? left_precision_i : right_prec_q;
    right_data_d = fwd_right ? left_data_i : right_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      err_q        <= 1'b0;
      tok_q        <= '0;
      bot_v_q      <= 1'b0;
      bot_cnt_q    <= '0;
      bot_data_q   <= '0;
      right_v_q    <= 1'b0;
      right_cnt_q  <= '0;
      right_type_q <= 1'b0;
      right_prec_q <= 1'b0;
      right_data_q <= '0;
      res_v_q      <= 1'b0;
      res_q        <= '0;
    end else begin
      acc_q        <= acc_d;
      err_q        <= err_d;
      tok_q        <= tok_d;
      bot_v_q      <= bot_v_d;
      bot_cnt_q    <= bot_cnt_d;
      bot_data_q   <= bot_data_d;
      right_v_q    <= right_v_d;
      right_cnt_q  <= right_cnt_d;
      right_type_q <= right_type_d;
      right_prec_q <= right_prec_d;
      right_data_q <= right_data_d;
      res_v_q      <= res_d.valid;
      res_q        <= res_d.data[ACC_W-1:0];
    end
  end

  assign bot_data_valid_o   = bot_v_q;
  assign bot_data_cnt_o     = bot_cnt_q;
  assign bot_data_o         = bot_data_q;
  assign bot_storec_valid_o = tok_q[1];
  assign bot_res_valid_o    = res_v_q;
  assign bot_res_o          = res_q;
  assign right_data_valid_o = right_v_q;
  assign right_data_cnt_o   = right_cnt_q;
  assign right_data_type_o  = right_type_q;
  assign right_precision_o  = right_prec_q;
  assign right_data_o       = right_data_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_pe_os_lane.sv
// Directed self-checking bench for pe_os_lane: single PE, a 16-bit accumulator PE
// sharing its stimulus, and a chained 4-row column for the result drain.
module tb_pe_os_lane;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus shared by u_dut and u_d16
  logic        top_v, storec, res_v_in, left_v, left_type, left_prec;
  logic [3:0]  top_cnt, left_cnt;
  logic [31:0] top_d, res_in, left_d;

  logic        bot_v, bot_tok, bres_v, r_v, r_type, r_prec, err;
  logic [3:0]  bot_cnt, r_cnt;
  logic [31:0] bot_d, bres, r_d;

  logic        d16_bot_v, d16_bot_tok, d16_bres_v, d16_r_v, d16_r_type, d16_r_prec, d16_err;
  logic [3:0]  d16_bot_cnt, d16_r_cnt;
  logic [31:0] d16_bot_d, d16_r_d;
  logic [15:0] d16_bres;

  pe_os_lane u_dut (
    .clk(clk), .rst(rst),
    .top_data_valid_i(top_v), .top_data_cnt_i(top_cnt), .top_data_i(top_d),
    .top_storec_valid_i(storec), .top_res_valid_i(res_v_in), .top_res_i(res_in),
    .left_data_valid_i(left_v), .left_data_cnt_i(left_cnt), .left_data_type_i(left_type),
    .left_precision_i(left_prec), .left_data_i(left_d),
    .bot_data_valid_o(bot_v), .bot_data_cnt_o(bot_cnt), .bot_data_o(bot_d),
    .bot_storec_valid_o(bot_tok), .bot_res_valid_o(bres_v), .bot_res_o(bres),
    .right_data_valid_o(r_v), .right_data_cnt_o(r_cnt), .right_data_type_o(r_type),
    .right_precision_o(r_prec), .right_data_o(r_d), .err_o(err)
  );

  pe_os_lane #(.ACC_W(16)) u_d16 (
    .clk(clk), .rst(rst),
    .top_data_valid_i(top_v), .top_data_cnt_i(top_cnt), .top_data_i(top_d),
    .top_storec_valid_i(storec), .top_res_valid_i(res_v_in), .top_res_i(res_in[15:0]),
    .left_data_valid_i(left_v), .left_data_cnt_i(left_cnt), .left_data_type_i(left_type),
    .left_precision_i(left_prec), .left_data_i(left_d),
    .bot_data_valid_o(d16_bot_v), .bot_data_cnt_o(d16_bot_cnt), .bot_data_o(d16_bot_d),
    .bot_storec_valid_o(d16_bot_tok), .bot_res_valid_o(d16_bres_v), .bot_res_o(d16_bres),
    .right_data_valid_o(d16_r_v), .right_data_cnt_o(d16_r_cnt), .right_data_type_o(d16_r_type),
    .right_precision_o(d16_r_prec), .right_data_o(d16_r_d), .err_o(d16_err)
  );

  // 4-row column with chained token and result
  logic        c_mac, col_tok;
  logic [31:0] c_a [4];
  logic [31:0] c_b [4];
  logic [4:0]  c_tok;
  logic [4:0]  c_rv;
  logic [31:0] c_res [5];
  assign c_tok[0] = col_tok;
  assign c_rv[0]  = 1'b0;
  assign c_res[0] = '0;

  for (genvar r = 0; r < 4; r++) begin : g_col
    logic        unused_bv, unused_rv, unused_rt, unused_rp, unused_e;
    logic [3:0]  unused_bc, unused_rc;
    logic [31:0] unused_bd, unused_rd;
    pe_os_lane #(.Y(r)) u_pe (
      .clk(clk), .rst(rst),
      .top_data_valid_i(c_mac), .top_data_cnt_i(4'd0), .top_data_i(c_b[r]),
      .top_storec_valid_i(c_tok[r]), .top_res_valid_i(c_rv[r]), .top_res_i(c_res[r]),
      .left_data_valid_i(c_mac), .left_data_cnt_i(4'd0), .left_data_type_i(1'b0),
      .left_precision_i(1'b0), .left_data_i(c_a[r]),
      .bot_data_valid_o(unused_bv), .bot_data_cnt_o(unused_bc), .bot_data_o(unused_bd),
      .bot_storec_valid_o(c_tok[r+1]), .bot_res_valid_o(c_rv[r+1]), .bot_res_o(c_res[r+1]),
      .right_data_valid_o(unused_rv), .right_data_cnt_o(unused_rc), .right_data_type_o(unused_rt),
      .right_precision_o(unused_rp), .right_data_o(unused_rd), .err_o(unused_e)
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        prec;
    int          n;
    logic [31:0] exp;
  } mac_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    top_v = 0; left_v = 0; storec = 0; res_v_in = 0; c_mac = 0; col_tok = 0;
    top_cnt = 0; left_cnt = 0; left_type = 0; left_prec = 0;
    top_d = 0; left_d = 0; res_in = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic load_c(input logic [31:0] c);
    idle();
    left_v = 1; left_type = 1; left_cnt = 4'd3; left_d = c;
    step();
  endtask

  task automatic mac(input logic [31:0] a, input logic [31:0] b, input logic tok);
    idle();
    top_v = 1; left_v = 1; top_d = b; left_d = a; storec = tok;
    step();
  endtask

  mac_vec_t vecs [6];
  int       seen;

  initial begin
    vecs[0] = '{32'h04030201, 32'h08070605, 1'b0, 2, 32'd140};
    vecs[1] = '{32'h01010101, 32'h01010101, 1'b0, 1, 32'd4};
    vecs[2] = '{32'h7F7F7F7F, 32'h11111111, 1'b1, 1, 32'd24};
    vecs[3] = '{32'h8003FEFF, 32'h7F020202, 1'b0, 1, 32'hFFFFC080};
    vecs[4] = '{32'h80808080, 32'h80808080, 1'b0, 3, 32'd196608};
    vecs[5] = '{32'h88888888, 32'h88888888, 1'b1, 1, 32'd512};
    for (int r = 0; r < 4; r++) begin
      c_a[r] = 32'(r + 1);
      c_b[r] = 32'(r + 1);
    end

    do_reset();
    chk("rst_bres_v", bres_v, 0);
    chk("rst_bres", bres, 0);
    chk("rst_tok", bot_tok, 0);
    chk("rst_err", err, 0);
    chk("rst_right_v", r_v, 0);
    chk("rst_bot_v", bot_v, 0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        idle();
        top_v = 1; left_v = 1; left_prec = vecs[i].prec;
        top_d = vecs[i].b; left_d = vecs[i].a; top_cnt = 4'(i);
        step();
        if (k == 0) begin
          chk($sformatf("v%0d_bot_v", i), bot_v, 1);
          chk($sformatf("v%0d_bot_d", i), bot_d, vecs[i].b);
          chk($sformatf("v%0d_bot_cnt", i), bot_cnt, 4'(i));
          chk($sformatf("v%0d_right_v", i), r_v, 1);
          chk($sformatf("v%0d_right_d", i), r_d, vecs[i].a);
        end
      end
      idle();
      storec = 1;
      step();
      storec = 0;
      chk($sformatf("v%0d_res_v", i), bres_v, 1);
      chk($sformatf("v%0d_res", i), bres, vecs[i].exp);
      chk($sformatf("v%0d_tok_t1", i), bot_tok, 0);
      step();
      chk($sformatf("v%0d_tok_t2", i), bot_tok, 1);
      chk($sformatf("v%0d_res_v_t2", i), bres_v, 0);
    end

    // C preload consumed at the matching column, forwarded otherwise
    load_c(32'd100);
    chk("c_hit_not_fwd", r_v, 0);
    mac(32'h01010101, 32'h01010101, 1'b0);
    idle(); storec = 1; step();
    chk("c_plus_mac", bres, 104);
    idle(); left_v = 1; left_type = 1; left_cnt = 0; left_d = 32'd55; step();
    chk("c_miss_fwd_v", r_v, 1);
    chk("c_miss_fwd_cnt", r_cnt, 0);
    chk("c_miss_fwd_type", r_type, 1);
    chk("c_miss_fwd_d", r_d, 55);

    // drain in the same cycle as a MAC
    load_c(32'd5);
    mac(32'h0000000A, 32'h00000001, 1'b1);
    chk("snap_mac_res", bres, 15);
    idle(); storec = 1; step();
    chk("after_drain_v", bres_v, 1);
    chk("after_drain_res", bres, 0);
    chk("aligned_no_err", err, 0);

    // lone words are dropped and flag an error
    idle(); top_v = 1; top_d = 32'h01010101; step();
    chk("lone_b_drop", bot_v, 0);
    chk("lone_b_err", err, 1);
    do_reset();
    chk("err_cleared", err, 0);
    idle(); left_v = 1; left_d = 32'h01010101; step();
    chk("lone_a_drop", r_v, 0);
    chk("lone_a_err", err, 1);

    // pass-through and collision on the result chain
    do_reset();
    idle(); res_v_in = 1; res_in = 32'd321; step();
    chk("pass_v", bres_v, 1);
    chk("pass_d", bres, 321);
    chk("pass_no_err", err, 0);
    load_c(32'd7);
    idle(); storec = 1; res_v_in = 1; res_in = 32'd999; step();
    chk("coll_own_v", bres_v, 1);
    chk("coll_own_d", bres, 7);
    chk("coll_err", err, 1);

    // 16-bit accumulator overflow
    do_reset();
    load_c(32'd32760);
    mac(32'h00000004, 32'h00000004, 1'b0);
    idle(); storec = 1; step();
`ifdef PE_OS_SAT_EN
    chk("acc16_res", d16_bres, 16'h7FFF);
    chk("acc16_err", d16_err, 1);
`else
    chk("acc16_res", d16_bres, 16'h8008);
    chk("acc16_err", d16_err, 0);
`endif

    // column drain: row r result at the bottom on cycle t0+4+r
    do_reset();
    idle(); c_mac = 1; step();
    idle(); col_tok = 1; step();
    col_tok = 0;
    for (int m = 1; m <= 9; m++) begin
      if (m > 1) step();
      if (m >= 4 && m <= 7) begin
        chk($sformatf("col_v_m%0d", m), c_rv[4], 1);
        chk($sformatf("col_d_m%0d", m), c_res[4], 32'((m - 3) * (m - 3)));
      end else begin
        chk($sformatf("col_v_m%0d", m), c_rv[4], 0);
      end
    end

    // reset in cycle t0+5 aborts the drain
    idle(); c_mac = 1; step();
    idle(); col_tok = 1; step();
    col_tok = 0;
    for (int m = 2; m <= 5; m++) step();
    chk("col_abort_pre_v", c_rv[4], 1);
    chk("col_abort_pre_d", c_res[4], 4);
    rst = 1;
    step();
    rst = 0;
    seen = 0;
    for (int m = 0; m < 8; m++) begin
      if (c_rv[4] || c_tok[4]) seen++;
      step();
    end
    chk("col_abort_none", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pe_os_lane.md
Name: pe_os_lane

Overview:
- Parametrised next-generation systolic processing element for the SARRAY output-stationary matrix engine.
- Each valid cycle it computes a LANES-wide signed dot product of the A word (from the left) and the B word (from the top), and accumulates it into an ACC_W accumulator.
- Accumulator preload (C) arrives on the left channel; the PE consumes it when the count matches this PE's column.
- Adds a result-drain path: a store token walks down the column, and each PE emits its accumulator on a dedicated result chain without collisions.

Parameters:
- X, 0, column index of this PE in the array.
- Y, 0, row index of this PE in the array.
- SARRAY_W, 4, array width (columns).
- LANES, 4, int8 elements per input word.
- ELEM_W, 8, element width in bits.
- ACC_W, 32, accumulator and result width.
- CNT_W, 4, count field width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- top_data_valid_i  in  1  B word valid
- top_data_cnt_i  in  CNT_W  B count
- top_data_i  in  LANES*ELEM_W  B word
- top_storec_valid_i  in  1  drain token from the row above
- top_res_valid_i  in  1  result from above valid
- top_res_i  in  ACC_W  result from above
- left_data_valid_i  in  1  left word valid
- left_data_cnt_i  in  CNT_W  left count
- left_data_type_i  in  1  0 = A, 1 = C
- left_precision_i  in  1  0 = int8 (LANES products), 1 = int4 (2*LANES products)
- left_data_i  in  LANES*ELEM_W  A word or C value (low ACC_W bits)
- bot_data_valid_o, bot_data_cnt_o, bot_data_o  out  1/CNT_W/LANES*ELEM_W  registered B forward
- bot_storec_valid_o  out  1  drain token forwarded downward
- bot_res_valid_o, bot_res_o  out  1/ACC_W  result chain output
- right_data_valid_o, right_data_cnt_o, right_data_type_o, right_precision_o, right_data_o  out  registered left forward
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: every output, the accumulator, the token pipe and err_o are 0. Reset mid-drain aborts the drain; no partial result is emitted afterwards.
- MAC fires when top_data_valid_i && left_data_valid_i && type==A.
  - int8: sum of the LANES signed 8x8 products, sign-extended to ACC_W.
  - int4: each byte splits into two signed nibbles; sum of the 2*LANES 4x4 products.
  - acc_next = acc + dot. Default overflow behaviour is wraparound (see Optional Feature).
- C hit: left valid && type==C && left_data_cnt_i == SARRAY_W-1-X.
  - On a hit, acc_next = C, and the word is not forwarded right.
  - C words without a hit are forwarded right.
- Forwarding latency:
  - B is forwarded down with 1-cycle latency, only when the MAC fires.
  - A is forwarded right with 1-cycle latency.
- Lone B or lone A:
  - a top word without a valid A, or an A without a valid B, is dropped and not forwarded;
  - such a lone word sets err_o (the array must feed A and B aligned).
- Drain: top_storec_valid_i sampled in cycle t.
  - Snapshot = acc_next of cycle t, i.e. it includes any MAC firing in cycle t.
  - bot_res_valid_o=1 and bot_res_o=snapshot in cycle t+1.
  - acc becomes 0, or C if a C hit occurs in the same cycle.
  - The token is forwarded downward through a 2-stage pipe; bot_storec_valid_o is asserted in cycle t+2.
- Result chain: when not emitting its own result, the PE registers top_res_valid_i/top_res_i to its bottom outputs (1-cycle pass-through).
  - With the 2-cycle token spacing, the row-r result reaches the bottom row output at t0+N+r, in order row 0..N-1.
- Collision (own emission and a valid pass-through in the same cycle): own result wins, the pass-through is dropped, err_o is set.
- A token arriving while a token is still in the pipe is accepted; the pipe is a 2-deep shift register, so back-to-back tokens are legal.
- err_o is cleared only by rst.

Optional Feature:
- Macro PE_OS_SAT_EN.
- Defined: accumulation, and a C preload followed by a MAC, saturate to the signed ACC_W limits; the first saturation event also sets err_o.
- Undefined: two's-complement wraparound, and saturation never sets err_o.

Decomposition:
- Shared package pe_pkg holds:
  - PE_DATA_TYPE_A/C and PRECISION_INT8/INT4 constants;
  - the result-chain struct (valid, data);
  - function sat_add.
- One sub-module, pe_dot_lane: combinational LANES-wide signed dot product with a precision select, instantiated once.
- The forward buffers and token pipe are plain registers inside pe_os_lane.

Test Plan:
- Setup for the scenarios below: X=0, Y=0, LANES=4, int8.
- A=[1,2,3,4], B=[5,6,7,8] for 2 cycles -> acc=140. Then token -> bot_res_o=140 one cycle later; bot_storec_valid_o two cycles after the token.
- C=100 with cnt=SARRAY_W-1 -> consumed, right_data_valid_o stays 0. A=B=[1,1,1,1] -> drain gives 104. C with cnt=0 -> forwarded right with cnt=0.
- int4: A byte 0x7F paired with B byte 0x11 in all lanes -> per-byte (7*1)+(-1*1)=6 -> acc=24.
- Token and a MAC of 10 in the same cycle with acc=5 -> result 15, acc=0 afterwards. A pass-through result arriving in the same cycle as the PE's own emission -> own result wins, err_o=1.
- 4-row column, tokens chained: bottom row output shows row 0..3 results on 4 consecutive cycles starting at t0+4; assert rst during cycle t0+5 -> no further bot_res_valid_o.
- PE_OS_SAT_EN, ACC_W=16: C=32760 loaded, then A=B=[4,0,0,0] (dot=16) -> acc=32767 and err_o=1. Without the macro -> acc=-32760.
